// File: rtl/instruction_queue.sv
// ---------------------------------------------------------------------------
// instruction_queue
//
// Decoupling FIFO between instruction fetch and decode/dispatch, with a
// static branch predictor on the fetch side. Each accepted {pc, instr} pair
// is pre-decoded as it is written:
//   - JAL is predicted taken.
//   - B-type branches are predicted taken only when backward (imm sign set).
//   - Everything else, including JALR, falls through to pc+4.
// A taken prediction redirects fetch in the same cycle the instruction is
// presented. The commit-side flush empties the whole queue.
//
// Parameters
//   DEPTH              number of entries (power of two, >= 2)
//
// Ports
//   clk_i              clock, rising edge
//   reset_ni           asynchronous active-low reset
//   fetch_valid_i      fetch presents a valid pc/instruction
//   fetch_pc_i         pc of the presented instruction
//   fetch_instr_i      presented instruction word
//   flush_i            pipeline flush; empties the queue
//   stall_o            fetch must hold its pc (queue full)
//   take_branch_o      fetch redirects to predicted_pc_o next edge
//   predicted_pc_o     redirect target (0 when no redirect)
//   deq_valid_o        head entry available to dispatch
//   deq_ready_i        dispatch accepts the head entry
//   deq_pc_o           head pc
//   deq_instr_o        head instruction
//   deq_pred_taken_o   head was predicted taken
//   deq_pred_target_o  head predicted target (pc+4 when not taken)
//   count_o            current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module instruction_queue #(
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic                     fetch_valid_i,
  input  logic [31:0]              fetch_pc_i,
  input  logic [31:0]              fetch_instr_i,
  input  logic                     flush_i,
  output logic                     stall_o,
  output logic                     take_branch_o,
  output logic [31:0]              predicted_pc_o,
  output logic                     deq_valid_o,
  input  logic                     deq_ready_i,
  output logic [31:0]              deq_pc_o,
  output logic [31:0]              deq_instr_o,
  output logic                     deq_pred_taken_o,
  output logic [31:0]              deq_pred_target_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Entry storage. Data only, so it carries no reset.
  logic [31:0] pc_mem     [DEPTH];
  logic [31:0] instr_mem  [DEPTH];
  logic        taken_mem  [DEPTH];
  logic [31:0] target_mem [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic        pred_taken;
  logic [31:0] pred_target;

  // J-type immediate, sign-extended to 32 bits.
  function automatic logic signed [31:0] jal_offset(input logic [31:0] ins);
    logic signed [31:0] off;
    off = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    return off;
  endfunction

  // B-type immediate, sign-extended to 32 bits.
  function automatic logic signed [31:0] branch_offset(input logic [31:0] ins);
    logic signed [31:0] off;
    off = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    return off;
  endfunction

  // Static prediction on the instruction currently presented by fetch.
  always_comb begin
    pred_taken  = 1'b0;
    pred_target = fetch_pc_i + 32'd4;
    case (fetch_instr_i[6:0])
      OP_JAL: begin
        pred_taken  = 1'b1;
        pred_target = fetch_pc_i + $unsigned(jal_offset(fetch_instr_i));
      end
      OP_BRANCH: begin
        // Backward branches are usually loop closers; forward ones fall through.
        if (fetch_instr_i[31]) begin
          pred_taken  = 1'b1;
          pred_target = fetch_pc_i + $unsigned(branch_offset(fetch_instr_i));
        end
      end
      default: begin
        pred_taken  = 1'b0;
        pred_target = fetch_pc_i + 32'd4;
      end
    endcase
  end

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // Flush has priority over both push and pop.
  assign push = fetch_valid_i & ~full & ~flush_i;
  assign deq_valid_o = ~empty & ~flush_i;
  assign pop  = deq_valid_o & deq_ready_i;

  // Stall depends on the count register only, so a pop while full does not
  // release it until the following cycle; fetch simply re-presents its pc.
  assign stall_o = full;

  // Redirect only for an instruction actually accepted; push already
  // excludes full, so take_branch_o never coincides with stall_o.
  assign take_branch_o  = push & pred_taken;
  assign predicted_pc_o = take_branch_o ? pred_target : 32'd0;

  assign deq_pc_o          = pc_mem[head_q];
  assign deq_instr_o       = instr_mem[head_q];
  assign deq_pred_taken_o  = taken_mem[head_q];
  assign deq_pred_target_o = target_mem[head_q];
  assign count_o           = count_q;

  // Next-state for pointers and occupancy. Pointers are PTR_W bits wide and
  // DEPTH is a power of two, so plain increment wraps modulo DEPTH.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + PTR_W'(1);
      if (pop)  head_d = head_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem[tail_q]     <= fetch_pc_i;
      instr_mem[tail_q]  <= fetch_instr_i;
      taken_mem[tail_q]  <= pred_taken;
      target_mem[tail_q] <= pred_target;
    end
  end

endmodule
